// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, schedule constants and rotate/shift helpers used by the
// message-schedule expander and the sigma CFUs.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int SCHED_WIN  = 16;
    localparam int MAX_ROUNDS = 64;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } sched_state_t;

    function automatic word_t ror32(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t shr32(input word_t x, input int unsigned n);
        return x >> n;
    endfunction

endpackage

// File: rtl/sha256_ssig.sv
// Combinational small-sigma function: SEL=0 gives ssig0, SEL=1 gives ssig1.
// The same block serves the sigma CFUs.
module sha256_ssig
    import sha256_pkg::*;
#(
    parameter int SEL = 0
) (
    input  word_t x_i,
    output word_t y_o
);

    generate
        if (SEL == 0) begin : g_ssig0
            assign y_o = ror32(x_i, 7) ^ ror32(x_i, 18) ^ shr32(x_i, 3);
        end else begin : g_ssig1
            assign y_o = ror32(x_i, 17) ^ ror32(x_i, 19) ^ shr32(x_i, 10);
        end
    endgenerate

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads W[0..15], then emits W[0..ROUNDS-1].
// Build option SHA256_SCHED_PERF_EN adds a saturating output-stall counter.
//
// Handshake rule (both ports): a word moves on a rising edge where valid and
// ready are both high; a raised valid stays high, with data held, until it moves.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = MAX_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic [5:0]   out_idx,
    output logic         done,
`ifdef SHA256_SCHED_PERF_EN
    output logic [15:0]  stall_cnt,
`endif
    output sched_state_t state_dbg
);

    localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);
    localparam logic [5:0] LOAD_LAST = 6'(SCHED_WIN - 1);

    sched_state_t state_q, state_d;
    word_t        win_q [SCHED_WIN];
    word_t        win_d [SCHED_WIN];
    logic [5:0]   cnt_q, cnt_d;
    logic         done_q, done_d;

    logic  in_fire, out_fire;
    word_t sig0_w, sig1_w, nxt_w;

    sha256_ssig #(.SEL(0)) u_ssig0 (.x_i(win_q[1]),  .y_o(sig0_w));
    sha256_ssig #(.SEL(1)) u_ssig1 (.x_i(win_q[14]), .y_o(sig1_w));

    // Window slot i holds W[t+i] while emitting W[t], so this is W[t+16].
    assign nxt_w = sig1_w + win_q[9] + sig0_w + win_q[0];

    assign in_fire  = in_valid  && (state_q == LOAD);
    assign out_fire = out_ready && (state_q == EMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: if (in_fire && cnt_q == LOAD_LAST) state_d = EMIT;
                EMIT: if (out_fire && cnt_q == LAST_IDX) state_d = LOAD;
                default: state_d = LOAD;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            LOAD: in_ready  = 1'b1;
            EMIT: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Flush leaves the window untouched; the next load overwrites all 16 slots.
    always_comb begin
        for (int i = 0; i < SCHED_WIN; i++) begin
            win_d[i] = win_q[i];
        end
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (flush) begin
            cnt_d = '0;
        end else if (in_fire) begin
            for (int i = 0; i < SCHED_WIN - 1; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[SCHED_WIN - 1] = in_data;
            cnt_d = (cnt_q == LOAD_LAST) ? 6'd0 : cnt_q + 6'd1;
        end else if (out_fire) begin
            for (int i = 0; i < SCHED_WIN - 1; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[SCHED_WIN - 1] = nxt_w;
            cnt_d  = (cnt_q == LAST_IDX) ? 6'd0 : cnt_q + 6'd1;
            done_d = (cnt_q == LAST_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SCHED_WIN; i++) begin
                win_q[i] <= '0;
            end
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            for (int i = 0; i < SCHED_WIN; i++) begin
                win_q[i] <= win_d[i];
            end
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign out_data  = win_q[0];
    assign out_idx   = cnt_q;
    assign done      = done_q;
    assign state_dbg = state_q;

`ifdef SHA256_SCHED_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Runs across blocks; only reset or flush bring it back to zero.
    always_comb begin
        stall_d = stall_q;
        if (flush) begin
            stall_d = '0;
        end else if (state_q == EMIT && !out_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: directed steps with random blocks and random
// back-pressure, checked against an index-based W[t] reference model.
module tb_sha256_msg_sched;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [5:0]   out_idx;
  logic         done;
  sched_state_t state_dbg;

  logic         s_in_ready;
  logic         s_out_valid;
  logic [31:0]  s_out_data;
  logic [5:0]   s_out_idx;
  logic         s_done;
  sched_state_t s_state_dbg;

`ifdef SHA256_SCHED_PERF_EN
  logic [15:0]  stall_cnt;
  logic [15:0]  s_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int stall_model = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_w[64];

  // ROUNDS=16 instance shares the input side; its output is always accepted.
  bit          mon16_en = 1'b0;
  logic [31:0] q16_data[$];
  logic [5:0]  q16_idx[$];
  int          last16_idx = -1;
  int          done16_after = -1;

  sha256_msg_sched #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .done(done),
`ifdef SHA256_SCHED_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .state_dbg(state_dbg)
  );

  sha256_msg_sched #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .out_idx(s_out_idx), .done(s_done),
`ifdef SHA256_SCHED_PERF_EN
    .stall_cnt(s_stall_cnt),
`endif
    .state_dbg(s_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon16_en) begin
      if (s_done) done16_after = last16_idx;
      if (s_out_valid) begin
        q16_data.push_back(s_out_data);
        q16_idx.push_back(s_out_idx);
        last16_idx = int'(s_out_idx);
      end
    end
  end

  // reference model
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_expected(input logic [31:0] blk[16]);
    logic [31:0] w[64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[t];
      else        w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
      exp_q.push_back(w[t]);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void stall_tick();
    if (stall_model < 16'hFFFF) stall_model++;
  endfunction

  // driver tasks
  task automatic load_words(input logic [31:0] blk[16], input int n);
    int guard;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = blk[k];
      guard = 0;
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) check("load_timeout", 32'(k), 32'(n));
      @(posedge clk);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: five stalls first then ready
  task automatic drain(input int mode, input string tag);
    int got, guard, stalls;
    bit stalled;
    logic [31:0] held_d;
    logic [5:0]  held_i;
    got = 0; guard = 0; stalls = 0; stalled = 1'b0;
    held_d = '0; held_i = '0;
    while (got < 64 && guard < 4000) begin
      @(negedge clk);
      in_valid = 1'b0;
      guard++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (stalls >= 5);
      endcase
      check($sformatf("%s_valid", tag), 32'(out_valid), 32'd1);
      if (stalled) begin
        check($sformatf("%s_hold_data", tag), out_data, held_d);
        check($sformatf("%s_hold_idx", tag), 32'(out_idx), 32'(held_i));
      end
      if (out_ready) begin
        check($sformatf("%s_w%0d", tag, got), out_data, exp_q.pop_front());
        check($sformatf("%s_idx%0d", tag, got), 32'(out_idx), 32'(got));
        got_w[got] = out_data;
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d = out_data;
        held_i = out_idx;
        stalls++;
        stall_tick();
      end
    end
    if (got < 64) check($sformatf("%s_timeout", tag), 32'(got), 32'd64);
    @(negedge clk);
    check($sformatf("%s_done", tag), 32'(done), 32'd1);
    check($sformatf("%s_post_valid", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s_post_ready", tag), 32'(in_ready), 32'd1);
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
  endtask

  task automatic random_block(output logic [31:0] blk[16]);
    for (int k = 0; k < 16; k++) blk[k] = $urandom;
  endtask

  initial begin
    logic [31:0] abc[16];
    logic [31:0] blk[16];
    int guard, got;
    bit hit;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int k = 0; k < 16; k++) abc[k] = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(LOAD));
`ifdef SHA256_SCHED_PERF_EN
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // abc block, full throughput; ROUNDS=16 instance runs alongside
    mon16_en = 1'b1;
    push_expected(abc);
    load_words(abc, 16);
    drain(0, "abc");
    mon16_en = 1'b0;
    check("abc_W16", got_w[16], 32'h61626380);
    check("abc_W17", got_w[17], 32'h000F0000);
    check("r16_count", 32'(q16_data.size()), 32'd16);
    for (int k = 0; k < 16 && k < q16_data.size(); k++) begin
      check($sformatf("r16_w%0d", k), q16_data[k], abc[k]);
      check($sformatf("r16_idx%0d", k), 32'(q16_idx[k]), 32'(k));
    end
    check("r16_done_after", 32'(done16_after), 32'd15);

    // same block with random back-pressure
    push_expected(abc);
    load_words(abc, 16);
    drain(1, "abc_rnd");
    check("abc_rnd_W17", got_w[17], 32'h000F0000);
`ifdef SHA256_SCHED_PERF_EN
    check("stall_cnt_rnd", 32'(stall_cnt), 32'(stall_model));
`endif

    // flush together with a handshake at out_idx 30
    random_block(blk);
    push_expected(blk);
    load_words(blk, 16);
    guard = 0; got = 0; hit = 1'b0;
    while (guard < 200) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard++;
      if (out_valid && out_idx == 6'd30) begin
        flush = 1'b1;
        hit = 1'b1;
        break;
      end
      if (out_valid) begin
        check($sformatf("fl_w%0d", got), out_data, exp_q.pop_front());
        got++;
      end
    end
    check("fl_reached_30", 32'(hit), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    stall_model = 0;
    exp_q.delete();
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_out_idx", 32'(out_idx), 32'd0);
    check("fl_done", 32'(done), 32'd0);
`ifdef SHA256_SCHED_PERF_EN
    check("fl_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // fresh block after flush, with exactly five stalls up front
    random_block(blk);
    push_expected(blk);
    load_words(blk, 16);
    drain(2, "after_fl");
`ifdef SHA256_SCHED_PERF_EN
    check("stall_cnt_five", 32'(stall_cnt), 32'd5);
    check("stall_cnt_model", 32'(stall_cnt), 32'(stall_model));
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    stall_model = 0;
    check("stall_cnt_flush", 32'(stall_cnt), 32'd0);
`endif

    // asynchronous reset mid-load after 7 words
    random_block(blk);
    load_words(blk, 7);
    #3;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_out_idx", 32'(out_idx), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(LOAD));
    @(negedge clk);
    rst = 1'b1;
    stall_model = 0;
    random_block(blk);
    push_expected(blk);
    load_words(blk, 16);
    drain(0, "post_rst");

    // random blocks under random back-pressure
    for (int b = 0; b < 3; b++) begin
      random_block(blk);
      push_expected(blk);
      load_words(blk, 16);
      drain(1, $sformatf("rnd%0d", b));
    end
`ifdef SHA256_SCHED_PERF_EN
    check("stall_cnt_final", 32'(stall_cnt), 32'(stall_model));
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
